// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential signed divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_nr_step.sv
// One non-restoring radix-2 iteration: shift {P,Q} left, add or subtract |D|, emit quotient bit.
module div_nr_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH:0]   d_abs,
  output logic [WIDTH:0]   p_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] p_sh;
  logic [WIDTH:0] addend;
  logic           sub;

  always_comb begin
    // |P| < |D| <= 2^(WIDTH-1), so the discarded top bit is only a sign copy
    p_sh   = {p_in[WIDTH-1:0], q_in[WIDTH-1]};
    sub    = ~p_in[WIDTH];
    addend = sub ? ~d_abs : d_abs;
    p_out  = p_sh + addend + {{WIDTH{1'b0}}, sub};
    q_out  = {q_in[WIDTH-2:0], ~p_out[WIDTH]};
  end

endmodule

// File: rtl/div_32_seq.sv
// Multi-cycle signed divider, result = {remainder, quotient}.
// Define DIV_ZERO_SHORTCUT_EN to finish a zero-divisor request straight from PREP.
module div_32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH);

  div_state_e state, state_nx;

  logic [WIDTH-1:0]   dvd_r, dvs_r;
  logic [WIDTH:0]     p, p_step, d_abs;
  logic [WIDTH-1:0]   q, q_step;
  logic [CW-1:0]      cnt;
  logic               sign_q, sign_r, dz;
  logic               dz_prep;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [WIDTH-1:0]   rem_mag, q_fin, r_fin;
  logic [2*WIDTH-1:0] result_r;
  logic               dbz_r;

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .p_in  (p),
    .q_in  (q),
    .d_abs (d_abs),
    .p_out (p_step),
    .q_out (q_step)
  );

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = PREP;
`ifdef DIV_ZERO_SHORTCUT_EN
      PREP: state_nx = dz_prep ? DONE : ITER;
`else
      PREP: state_nx = ITER;
`endif
      ITER: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_comb begin
    dz_prep = (dvs_r == '0);
    // WIDTH-bit unsigned magnitude already holds 2^(WIDTH-1) for the most negative operand
    dvd_mag = dvd_r[WIDTH-1] ? (~dvd_r + 1'b1) : dvd_r;
    dvs_mag = dvs_r[WIDTH-1] ? (~dvs_r + 1'b1) : dvs_r;
    rem_mag = p[WIDTH] ? (p[WIDTH-1:0] + d_abs[WIDTH-1:0]) : p[WIDTH-1:0];
    q_fin   = sign_q ? (~q + 1'b1) : q;
    r_fin   = sign_r ? (~rem_mag + 1'b1) : rem_mag;
    if (dz) begin
      q_fin = '1;
      r_fin = dvd_r;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      dvd_r    <= '0;
      dvs_r    <= '0;
      p        <= '0;
      q        <= '0;
      d_abs    <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dz       <= 1'b0;
      result_r <= '0;
      dbz_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
          end
        end
        PREP: begin
          sign_q <= dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1];
          sign_r <= dvd_r[WIDTH-1];
          dz     <= dz_prep;
          d_abs  <= {1'b0, dvs_mag};
          q      <= dvd_mag;
          p      <= '0;
          cnt    <= CW'(WIDTH - 1);
`ifdef DIV_ZERO_SHORTCUT_EN
          if (dz_prep) begin
            result_r <= {dvd_r, {WIDTH{1'b1}}};
            dbz_r    <= 1'b1;
          end
`endif
        end
        ITER: begin
          p   <= p_step;
          q   <= q_step;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          result_r <= {r_fin, q_fin};
          dbz_r    <= dz;
        end
        default: ;
      endcase
    end
  end

  assign result      = result_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq: directed cases plus randomized signed pairs vs. a / % model.
module tb_div_32_seq;

  logic        clock = 1'b0;
  logic        clear, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  div_32_seq #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] res, output logic dz);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    dz = 1'b0;
    if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
      dz  = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = {32'd0, 32'h8000_0000};
    end else begin
      res = {32'(sa % sb), 32'(sa / sb)};
    end
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_SHORTCUT_EN
    return (b == 32'd0) ? 2 : 35;
`else
    return 35;
`endif
  endfunction

  // Issue one division, count cycles to done, check result, busy window and hold behaviour.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [63:0] er,
                     input logic edz, input string tag, input bit poke_done);
    int lat;
    bit busy_ok;
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat      = 1;
    busy_ok  = 1'b1;
    while (!done && lat < 100) begin
      busy_ok &= busy;
      @(negedge clock);
      lat++;
    end
    busy_ok &= busy;
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(b)));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_res"}, result, er);
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(edz));
    if (poke_done) begin
      start    = 1'b1;
      dividend = 32'd1;
      divisor  = 32'd1;
    end
    @(negedge clock);
    start = 1'b0;
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    @(negedge clock);
    check({tag, "_hold"}, result, er);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [63:0] er;
    logic        edz;
    int          n;

    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clock);
    check("reset_out", {busy, done, div_by_zero, result}, '0);
    clear = 1'b0;

    run(32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, "p100_7", 1'b0);
    run(-32'd100, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0, "n100_7", 1'b0);
    run(32'd100, -32'd7, {32'd2, 32'hFFFF_FFF2}, 1'b0, "p100_n7", 1'b0);
    run(-32'd100, -32'd7, {32'hFFFF_FFFE, 32'd14}, 1'b0, "n100_n7", 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, "ovf", 1'b0);
    run(32'h8000_0000, 32'd1, {32'd0, 32'h8000_0000}, 1'b0, "min_1", 1'b0);
    run(32'd55, 32'd0, {32'd55, 32'hFFFF_FFFF}, 1'b1, "dz55", 1'b0);
    run(-32'd9, 32'd0, {32'hFFFF_FFF7, 32'hFFFF_FFFF}, 1'b1, "dzn9", 1'b0);
    run(32'd7, 32'd100, {32'd7, 32'd0}, 1'b0, "small", 1'b1);

    // start re-pulsed mid-iteration must be ignored
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if (n == 10) begin
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    check("repulse_lat", 64'(n), 64'd35);
    check("repulse_res", result, {32'd2, 32'd14});
    @(negedge clock);
    check("repulse_idle", 64'(busy), 64'd0);

    // clear mid-operation aborts without a done pulse; previous dz flag forced to 0
    run(32'd3, 32'd0, {32'd3, 32'hFFFF_FFFF}, 1'b1, "pre_clr", 1'b0);
    @(negedge clock);
    dividend = 32'd1234;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr_state", {busy, done, div_by_zero, result}, '0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done || busy) n++;
    end
    check("clr_nodone", 64'(n), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case (i % 5)
        0: b = $urandom;
        1: b = 32'(int'($urandom_range(0, 30)) - 15);
        2: b = $urandom >> $urandom_range(0, 31);
        3: begin
          a = 32'(int'($urandom_range(0, 2000)) - 1000);
          b = 32'(int'($urandom_range(0, 60)) - 30);
        end
        default: begin
          a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : a;
          b = -($urandom >> $urandom_range(0, 31));
        end
      endcase
      model(a, b, er, edz);
      run(a, b, er, edz, $sformatf("rnd%0d", i), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
